uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//   On-chip UART transmit path: the FPGA_SERIAL_TX end of the serial link to the host.
//   Buffers bytes from the CPU MMIO store path in a small FIFO.
//   Serializes each byte as an 8N1 frame on serial_out.
//   Frames are sent back-to-back while data is queued.
//   Lets BIOS echo/printout proceed without the CPU stalling once per character.
// PARAMETERS
//   CLOCK_FREQ  50_000_000  clk frequency in Hz
//   BAUD_RATE   10_000_000  line rate in bit/s
//                           CYCLES_PER_BIT = CLOCK_FREQ/BAUD_RATE (integer division, must be >= 2)
//   DEPTH       8           FIFO entries; power of 2, >= 2
// PORTS
//   clk            in   1              system clock; all logic is on its rising edge
//   rst            in   1              synchronous reset, active-high
//   data_in        in   8              byte to transmit
//   data_in_valid  in   1              producer offers data_in
//   data_in_ready  out  1              FIFO can accept; transfer = valid & ready at posedge
//   serial_out     out  1              UART line; idles high
//   tx_busy        out  1              frame in progress OR FIFO non-empty
//   fifo_count     out  $clog2(DEPTH)+1   occupied entries, 0..DEPTH
// BEHAVIOUR
//   Reset (clk edge with rst=1), values visible after that edge:
//     serial_out=1; data_in_ready=1; tx_busy=0; fifo_count=0.
//     FIFO pointers, bit counter and baud counter are zeroed.
//     A frame in flight is abandoned: the line returns high immediately.
//     No partial frame resumes after rst deasserts.
//   FIFO:
//     Write on data_in_valid & data_in_ready.
//     data_in_ready = (fifo_count != DEPTH); it is a function of the registered count only.
//     A pop in the same cycle does not raise ready while full.
//     Pointers wrap modulo DEPTH.
//     Simultaneous push and pop: count unchanged, both take effect.
//     data_in_valid while full: byte ignored, no state change.
//   Transmitter FSM (registered serial_out):
//     IDLE:
//       serial_out=1.
//       If FIFO non-empty at an edge: pop head into shift reg, go START.
//       serial_out=0 from that same edge.
//     START: hold 0 for CYCLES_PER_BIT cycles, then go DATA.
//     DATA:
//       8 bits, LSB first, each held CYCLES_PER_BIT cycles.
//       3-bit index counts 0..7; after bit 7 go STOP.
//     STOP: hold 1 for CYCLES_PER_BIT cycles.
//       At the end edge, if FIFO non-empty: pop and go START (no idle gap).
//       Otherwise go IDLE.
//   Timing:
//     Frame = exactly 10*CYCLES_PER_BIT cycles.
//     Baud counter reloads at every bit boundary; there is no accumulated drift.
//     A byte written at edge k into an empty FIFO with the FSM in IDLE is popped at edge k+1.
//     serial_out falls to 0 after edge k+1.
//     fifo_count shows 1 after edge k and 0 after edge k+1.
//   tx_busy = (state != IDLE) | (fifo_count != 0).
//   No X on any output after the first reset edge; data_in is not sampled unless valid.
// TESTING
//   (CLOCK_FREQ=50M, BAUD_RATE=10M -> 5 cycles/bit, 50 cycles/frame; host monitor samples mid-bit)
//   1. Reset: hold rst 10 cycles.
//      -> serial_out=1, data_in_ready=1, tx_busy=0, fifo_count=0 throughout.
//   2. Single byte: push 8'h31 once.
//      -> serial_out low 1 cycle later.
//      -> monitor decodes 8'h31 with stop bit 1.
//      -> tx_busy drops exactly 50 cycles after the start edge.
//   3. Burst: push "\r\n151> " (0d 0a 31 35 31 3e 20) on consecutive cycles.
//      -> all 7 bytes received in order.
//      -> back-to-back frames with no idle gap, 350 cycles total.
//   4. Full: push 9 bytes without gaps.
//      -> fifo_count rises to 8 (one byte already popped into the shifter), data_in_ready=0.
//      -> the 10th offered byte is dropped.
//      -> the first 9 bytes are received intact.
//   5. Wrap / simultaneous: keep the FIFO at 1-2 entries while streaming 20 bytes (00..13).
//      -> pointers wrap twice.
//      -> a push coincident with a pop leaves fifo_count unchanged.
//      -> all 20 bytes are received in order.
//   6. Reset mid-frame: assert rst during data bit 3 of 8'hAA with 3 bytes queued.
//      -> serial_out=1 the next cycle, fifo_count=0.
//      -> no further start bit is seen until a new push.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART transmit path: DEPTH-entry byte FIFO feeding an 8N1 serializer.
// Frames go out back-to-back while bytes are queued; serial_out is registered.
module uart_tx_fifo #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 10_000_000,
    parameter int DEPTH      = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               data_in,
    input  logic                     data_in_valid,
    output logic                     data_in_ready,
    output logic                     serial_out,
    output logic                     tx_busy,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int CPB = CLOCK_FREQ / BAUD_RATE;
    localparam int AW  = $clog2(DEPTH);
    localparam int BW  = $clog2(CPB);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CPB - 1);
    localparam logic [AW:0]   FULL      = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    state_t        state;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          baud_end, push, pop;

    assign baud_end      = (baud_cnt == BAUD_LAST);
    assign data_in_ready = (fifo_count != FULL);
    assign push          = data_in_valid & data_in_ready;
    // Pop either from idle or at the last cycle of a stop bit, so frames chain with no gap.
    assign pop           = (fifo_count != '0) & ((state == IDLE) | ((state == STOP) & baud_end));
    assign tx_busy       = (state != IDLE) | (fifo_count != '0);

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            serial_out <= 1'b1;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shift      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    serial_out <= 1'b1;
                    baud_cnt   <= '0;
                    if (pop) begin
                        shift      <= mem[rd_ptr];
                        serial_out <= 1'b0;
                        state      <= START;
                    end
                end
                START: begin
                    if (baud_end) begin
                        baud_cnt   <= '0;
                        bit_idx    <= '0;
                        serial_out <= shift[0];
                        shift      <= {1'b0, shift[7:1]};
                        state      <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            serial_out <= 1'b1;
                            state      <= STOP;
                        end else begin
                            bit_idx    <= bit_idx + 3'd1;
                            serial_out <= shift[0];
                            shift      <= {1'b0, shift[7:1]};
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (pop) begin
                            shift      <= mem[rd_ptr];
                            serial_out <= 1'b0;
                            state      <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    serial_out <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: frame-level reference model, mid-bit line decoder,
// and directed scenarios (reset, single byte, burst, full, streaming wrap, reset mid-frame).
module tb_uart_tx_fifo;
    localparam int CPB   = 5;
    localparam int DEPTH = 8;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       data_in_valid = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       data_in_ready, serial_out, tx_busy;
    logic [3:0] fifo_count;

    uart_tx_fifo #(.CLOCK_FREQ(50_000_000), .BAUD_RATE(10_000_000), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid),
        .data_in_ready(data_in_ready), .serial_out(serial_out), .tx_busy(tx_busy),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: queue of waiting bytes plus the frame currently on the wire,
    // tracked as a cycle offset into a 10-bit-time frame.
    logic [7:0] mq[$];
    logic [7:0] m_cur;
    bit         m_active = 0, model_ok = 0;
    int         m_t = 0, m_n = 0;

    function automatic logic m_serial();
        int b;
        if (!m_active) return 1'b1;
        b = m_t / CPB;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return m_cur[b-1];
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
        if (rst) begin
            mq.delete();
            m_active = 0;
            m_t = 0;
            model_ok = 1;
        end else begin
            m_n = mq.size();
            if (m_active && m_t != FRAME - 1) m_t++;
            else if (m_n > 0) begin
                m_cur = mq.pop_front();
                m_active = 1;
                m_t = 0;
            end else m_active = 0;
            if (data_in_valid && m_n != DEPTH) mq.push_back(data_in);
        end
    end

    initial forever begin
        @(negedge clk);
        if (model_ok) begin
            chk("serial_out", serial_out, m_serial());
            chk("data_in_ready", data_in_ready, mq.size() != DEPTH);
            chk("tx_busy", tx_busy, m_active || mq.size() != 0);
            chk("fifo_count", fifo_count, mq.size());
        end
    end

    // Host-side decoder sampling each bit at its middle.
    logic [7:0] rxq[$];
    logic [7:0] mon_sh = 8'h00;
    bit         mon_active = 0;
    int         mon_t = 0, mon_starts = 0, mon_b = 0;

    initial forever begin
        @(negedge clk);
        if (rst || !model_ok) mon_active = 0;
        else if (!mon_active) begin
            if (serial_out === 1'b0) begin
                mon_active = 1;
                mon_t = 0;
                mon_starts++;
            end
        end else begin
            mon_t++;
            if (mon_t % CPB == CPB / 2) begin
                mon_b = mon_t / CPB;
                if (mon_b >= 1 && mon_b <= 8) mon_sh[mon_b-1] = serial_out;
                else if (mon_b == 9) begin
                    chk("stop bit", serial_out, 1'b1);
                    rxq.push_back(mon_sh);
                    mon_active = 0;
                end
            end
        end
    end

    task automatic wait_idle(input string nm);
        int n = 0;
        while (tx_busy !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk(nm, tx_busy, 1'b0);
    endtask

    task automatic chk_rx(input string nm, input logic [7:0] exp[$]);
        chk({nm, " count"}, rxq.size(), exp.size());
        for (int i = 0; i < exp.size() && i < rxq.size(); i++) chk(nm, rxq[i], exp[i]);
    endtask

    logic [7:0] expq[$];
    logic [7:0] msg3 [7] = '{8'h0d, 8'h0a, 8'h31, 8'h35, 8'h31, 8'h3e, 8'h20};
    int k, sent, n, starts0;

    initial begin
        // 1. reset held for 10 cycles
        repeat (10) begin
            @(negedge clk);
            chk("rst serial_out", serial_out, 1'b1);
            chk("rst ready", data_in_ready, 1'b1);
            chk("rst busy", tx_busy, 1'b0);
            chk("rst count", fifo_count, 4'd0);
        end
        rst = 1'b0;

        // 2. single byte
        @(negedge clk);
        rxq.delete();
        data_in_valid = 1'b1; data_in = 8'h31;
        @(negedge clk);
        k = cyc; data_in_valid = 1'b0;
        chk("single count after push", fifo_count, 4'd1);
        chk("single line still idle", serial_out, 1'b1);
        @(negedge clk);
        chk("single start bit", serial_out, 1'b0);
        chk("single count after pop", fifo_count, 4'd0);
        wait_idle("single idle");
        chk("single frame length", cyc - (k + 1), FRAME);
        expq = '{8'h31};
        chk_rx("single rx", expq);

        // 3. burst of 7 bytes, back-to-back frames
        rxq.delete();
        for (int i = 0; i < 7; i++) begin
            data_in_valid = 1'b1; data_in = msg3[i];
            @(negedge clk);
            if (i == 0) k = cyc;
        end
        data_in_valid = 1'b0;
        wait_idle("burst idle");
        chk("burst total length", cyc - (k + 1), 7 * FRAME);
        expq.delete();
        for (int i = 0; i < 7; i++) expq.push_back(msg3[i]);
        chk_rx("burst rx", expq);

        // 4. fill: 10 offered, 9 accepted, one already in the shifter
        rxq.delete();
        for (int i = 0; i < 10; i++) begin
            data_in_valid = 1'b1; data_in = 8'h40 + 8'(i);
            @(negedge clk);
            if (i == 1) chk("push+pop count", fifo_count, 4'd1);
            if (i == 8) begin
                chk("full count", fifo_count, 4'd8);
                chk("full ready", data_in_ready, 1'b0);
            end
            if (i == 9) chk("drop keeps count", fifo_count, 4'd8);
        end
        data_in_valid = 1'b0;
        wait_idle("full idle");
        expq.delete();
        for (int i = 0; i < 9; i++) expq.push_back(8'h40 + 8'(i));
        chk_rx("full rx", expq);

        // 5. stream 20 bytes keeping the FIFO at 1-2 entries
        rxq.delete();
        sent = 0; n = 0;
        while (sent < 20 && n < 3000) begin
            @(negedge clk);
            n++;
            if (fifo_count < 4'd2) begin
                data_in_valid = 1'b1; data_in = 8'(sent);
                sent++;
            end else data_in_valid = 1'b0;
        end
        @(negedge clk);
        data_in_valid = 1'b0;
        chk("stream all sent", sent, 20);
        wait_idle("stream idle");
        expq.delete();
        for (int i = 0; i < 20; i++) expq.push_back(8'(i));
        chk_rx("stream rx", expq);

        // 6. reset during data bit 3 of 8'hAA with three bytes queued
        rxq.delete();
        for (int i = 0; i < 4; i++) begin
            data_in_valid = 1'b1; data_in = (i == 0) ? 8'hAA : 8'(i);
            @(negedge clk);
            if (i == 0) k = cyc;
        end
        data_in_valid = 1'b0;
        while (cyc < k + 1 + 4 * CPB + 1) @(negedge clk);
        chk("pre-reset queued", fifo_count, 4'd3);
        rst = 1'b1;
        starts0 = mon_starts;
        @(negedge clk);
        chk("midrst serial_out", serial_out, 1'b1);
        chk("midrst count", fifo_count, 4'd0);
        chk("midrst busy", tx_busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (200) @(negedge clk);
        chk("no start after reset", mon_starts - starts0, 0);
        chk("no byte after reset", rxq.size(), 0);
        data_in_valid = 1'b1; data_in = 8'h55;
        @(negedge clk);
        data_in_valid = 1'b0;
        wait_idle("recover idle");
        expq = '{8'h55};
        chk_rx("recover rx", expq);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
